// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operand/result bundle between EX-stage issue logic and the mul/div unit
//
// Purpose: groups the launch, move, flush and result signals of the
// iterative multiply/divide unit so they travel as one port.
// Signals:
//   start   launch an operation (only honoured while idle)
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a   rs operand: multiplicand / dividend / MTHI-MTLO data
//   src_b   rt operand: multiplier / divisor
//   cancel  pipeline flush, aborts an in-flight operation
//   mthi    write src_a into HI
//   mtlo    write src_a into LO
//   hi_out  HI register
//   lo_out  LO register
//   busy    operation in flight
//   done    one-cycle pulse when HI/LO were written by an operation
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, src_a, src_b, cancel, mthi, mtlo,
    input  hi_out, lo_out, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, mthi, mtlo,
    output hi_out, lo_out, busy, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
//
// Purpose: executes one multiply or divide over WIDTH iterations on
// operand magnitudes, then applies sign correction and writes HI/LO.
// Also services MTHI/MTLO while idle.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   mdu     muldiv_unit_if.slave (start/op/src_a/src_b/cancel/mthi/mtlo in,
//           hi_out/lo_out/busy/done out)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  muldiv_unit_if.slave  mdu
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q;
  logic               is_div_q;
  logic               neg_res_q;   // quotient/product must be negated
  logic               neg_rem_q;   // remainder takes the dividend's sign
  logic               div0_q;      // divisor was zero
  logic [WIDTH-1:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // Launch-time operand conditioning
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    op_signed = ~mdu.op[0];
    a_neg     = op_signed & mdu.src_a[WIDTH-1];
    b_neg     = op_signed & mdu.src_b[WIDTH-1];
    a_mag     = a_neg ? (~mdu.src_a + 1'b1) : mdu.src_a;
    b_mag     = b_neg ? (~mdu.src_b + 1'b1) : mdu.src_b;
  end

  // One iteration of either algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_upper;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (LSB) is set, then shift the whole register right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + ({(WIDTH+1){acc_q[0]}} & {1'b0, opnd_q});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift {rem,quo} left, trial-subtract the divisor
    // from the widened remainder, keep the difference only if non-negative.
    // The extra bit is needed because the shifted remainder can reach 2*divisor-1.
    div_upper = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_upper - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_upper[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    acc_d = is_div_q ? div_next : mul_next;
  end

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    // With a zero divisor every trial subtract succeeds, so the remainder
    // ends up equal to the dividend magnitude; re-applying the dividend's
    // sign yields src_a exactly. Only the quotient needs forcing.
    if (div0_q) begin
      quo_fix = '1;
    end else begin
      quo_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end
    rem_fix = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // cancel is meaningless here and must not block a start
          if (mdu.start) begin
            is_div_q  <= mdu.op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            div0_q    <= ~|mdu.src_b;
            opnd_q    <= mdu.op[1] ? b_mag : a_mag;
            acc_q     <= mdu.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end else begin
            if (mdu.mthi) hi_q <= mdu.src_a;
            if (mdu.mtlo) lo_q <= mdu.src_a;
          end
        end

        S_RUN: begin
          if (mdu.cancel) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= S_FIX;
            end
          end
        end

        S_FIX: begin
          if (!mdu.cancel) begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mdu.hi_out = hi_q;
  assign mdu.lo_out = lo_q;
  assign mdu.busy   = busy_q;
  assign mdu.done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) mdu_if ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .mdu    (mdu_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  // Reference: plain integer arithmetic, {HI, LO}
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = '0;
    case (op)
      2'b00: begin p = sa * sb; res = 64'(p); end
      2'b01: begin up = ua * ub; res = up; end
      2'b10: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Launch one op and observe 40 cycles. disturb: 0 none, 1 moves at busy
  // cycle 3, 2 second start at busy cycle 10.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mv, input logic cc, input int disturb,
                        output int nb, output int nd, output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk);
    mdu_if.op = op; mdu_if.src_a = a; mdu_if.src_b = b;
    mdu_if.start = 1'b1; mdu_if.mthi = mv; mdu_if.mtlo = mv; mdu_if.cancel = cc;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0; mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b0; mdu_if.cancel = 1'b0;
    mdu_if.src_a = $urandom; mdu_if.src_b = $urandom;
    nb = 0; nd = 0; hi = 'x; lo = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mdu_if.busy) nb++;
      if (mdu_if.done) begin nd++; hi = mdu_if.hi_out; lo = mdu_if.lo_out; end
      if (disturb == 1 && k == 3) begin mdu_if.mthi = 1'b1; mdu_if.mtlo = 1'b1; mdu_if.src_a = $urandom; end
      if (disturb == 2 && k == 10) begin mdu_if.start = 1'b1; mdu_if.op = 2'($urandom_range(0, 3)); end
      if (k == 4 || k == 11) begin mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b0; mdu_if.start = 1'b0; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mdu_if.hi_out !== 32'h0) $display("FAIL reset_hi: got %h expected 0", mdu_if.hi_out); else n_pass++;
    n_checks++; if (mdu_if.lo_out !== 32'h0) $display("FAIL reset_lo: got %h expected 0", mdu_if.lo_out); else n_pass++;
    n_checks++; if (mdu_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", mdu_if.busy); else n_pass++;
    n_checks++; if (mdu_if.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", mdu_if.done); else n_pass++;
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] as  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
    logic [31:0] bs  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
    int nb, nd;
    logic [31:0] hi, lo;
    logic [63:0] r;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, 1'b0, 0, nb, nd, hi, lo);
      r = ref_mdu(ops[i], as[i], bs[i]);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      n_checks++; if (nb != 33) $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, nb); else n_pass++;
      n_checks++; if (nd != 1) $display("FAIL dir%0d_done_pulses: got %0d expected 1", i, nd); else n_pass++;
      n_checks++; if (hi !== exp_hi) $display("FAIL dir%0d_hi: got %h expected %h", i, hi, exp_hi); else n_pass++;
      n_checks++; if (lo !== exp_lo) $display("FAIL dir%0d_lo: got %h expected %h", i, lo, exp_lo); else n_pass++;
    end
  endtask

  task automatic test_random();
    int nb, nd;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [63:0] r;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(op, a, b, 1'b0, 1'b0, 0, nb, nd, hi, lo);
      r = ref_mdu(op, a, b);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      n_checks++; if (nd != 1 || nb != 33) $display("FAIL rnd%0d_timing: got busy=%0d done=%0d expected 33/1", i, nb, nd); else n_pass++;
      n_checks++; if (hi !== exp_hi) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi, exp_hi); else n_pass++;
      n_checks++; if (lo !== exp_lo) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo, exp_lo); else n_pass++;
    end
  endtask

  task automatic test_moves();
    logic [31:0] v;
    int nb, nd;
    logic [31:0] hi, lo, a, b;
    logic [63:0] r;
    @(negedge clk); mdu_if.mthi = 1'b1; mdu_if.src_a = 32'h0000_1234;
    @(posedge clk); #1; mdu_if.mthi = 1'b0; exp_hi = 32'h0000_1234;
    @(negedge clk);
    n_checks++; if (mdu_if.hi_out !== exp_hi) $display("FAIL mthi_hi: got %h expected %h", mdu_if.hi_out, exp_hi); else n_pass++;
    n_checks++; if (mdu_if.lo_out !== exp_lo) $display("FAIL mthi_lo_kept: got %h expected %h", mdu_if.lo_out, exp_lo); else n_pass++;
    v = $urandom;
    mdu_if.mtlo = 1'b1; mdu_if.src_a = v;
    @(posedge clk); #1; mdu_if.mtlo = 1'b0; exp_lo = v;
    @(negedge clk);
    n_checks++; if (mdu_if.lo_out !== exp_lo || mdu_if.hi_out !== exp_hi) $display("FAIL mtlo: got %h_%h expected %h_%h", mdu_if.hi_out, mdu_if.lo_out, exp_hi, exp_lo); else n_pass++;
    v = $urandom;
    mdu_if.mthi = 1'b1; mdu_if.mtlo = 1'b1; mdu_if.src_a = v;
    @(posedge clk); #1; mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b0; exp_hi = v; exp_lo = v;
    @(negedge clk);
    n_checks++; if (mdu_if.lo_out !== exp_lo || mdu_if.hi_out !== exp_hi) $display("FAIL mthi_mtlo: got %h_%h expected %h_%h", mdu_if.hi_out, mdu_if.lo_out, exp_hi, exp_lo); else n_pass++;
    // start together with moves: start wins; cancel in idle does not block
    a = $urandom; b = $urandom;
    run_op(2'b01, a, b, 1'b1, 1'b1, 0, nb, nd, hi, lo);
    r = ref_mdu(2'b01, a, b);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    n_checks++; if (nd != 1 || nb != 33) $display("FAIL start_over_moves_timing: got busy=%0d done=%0d expected 33/1", nb, nd); else n_pass++;
    n_checks++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL start_over_moves: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); else n_pass++;
  endtask

  task automatic test_busy_ignores();
    int nb, nd;
    logic [31:0] hi, lo, a, b;
    logic [63:0] r;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    run_op(2'b10, a, b, 1'b0, 1'b0, 1, nb, nd, hi, lo);
    r = ref_mdu(2'b10, a, b);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    n_checks++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL moves_while_busy: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); else n_pass++;
    n_checks++; if (mdu_if.hi_out !== exp_hi || mdu_if.lo_out !== exp_lo) $display("FAIL moves_while_busy_after: got %h_%h expected %h_%h", mdu_if.hi_out, mdu_if.lo_out, exp_hi, exp_lo); else n_pass++;
    a = $urandom; b = $urandom;
    run_op(2'b00, a, b, 1'b0, 1'b0, 2, nb, nd, hi, lo);
    r = ref_mdu(2'b00, a, b);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    n_checks++; if (nb != 33 || nd != 1) $display("FAIL start_while_busy_timing: got busy=%0d done=%0d expected 33/1", nb, nd); else n_pass++;
    n_checks++; if (hi !== exp_hi || lo !== exp_lo) $display("FAIL start_while_busy: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); else n_pass++;
  endtask

  task automatic test_cancel();
    int nd;
    @(negedge clk); mdu_if.mthi = 1'b1; mdu_if.src_a = 32'h0000_AAAA;
    @(negedge clk); mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b1; mdu_if.src_a = 32'h0000_5555;
    @(negedge clk); mdu_if.mtlo = 1'b0;
    exp_hi = 32'h0000_AAAA; exp_lo = 32'h0000_5555;
    mdu_if.op = 2'b10; mdu_if.src_a = $urandom; mdu_if.src_b = 32'($urandom_range(1, 99)); mdu_if.start = 1'b1;
    @(posedge clk); #1; mdu_if.start = 1'b0;
    repeat (5) @(negedge clk);
    mdu_if.cancel = 1'b1;
    @(posedge clk); #1; mdu_if.cancel = 1'b0;
    @(negedge clk);
    n_checks++; if (mdu_if.busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", mdu_if.busy); else n_pass++;
    nd = 0;
    repeat (40) begin @(negedge clk); if (mdu_if.done) nd++; end
    n_checks++; if (nd != 0) $display("FAIL cancel_done: got %0d pulses expected 0", nd); else n_pass++;
    n_checks++; if (mdu_if.hi_out !== exp_hi || mdu_if.lo_out !== exp_lo) $display("FAIL cancel_hilo: got %h_%h expected %h_%h", mdu_if.hi_out, mdu_if.lo_out, exp_hi, exp_lo); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nb, nd;
    logic [31:0] hi, lo, a, b;
    logic [63:0] r;
    @(negedge clk); mdu_if.mthi = 1'b1; mdu_if.mtlo = 1'b1; mdu_if.src_a = $urandom | 32'h1;
    @(negedge clk); mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b0;
    mdu_if.op = 2'b01; mdu_if.src_a = $urandom; mdu_if.src_b = $urandom; mdu_if.start = 1'b1;
    @(posedge clk); #1; mdu_if.start = 1'b0;
    repeat (10) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    n_checks++; if (mdu_if.hi_out !== 32'h0) $display("FAIL areset_hi: got %h expected 0", mdu_if.hi_out); else n_pass++;
    n_checks++; if (mdu_if.lo_out !== 32'h0) $display("FAIL areset_lo: got %h expected 0", mdu_if.lo_out); else n_pass++;
    n_checks++; if (mdu_if.busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", mdu_if.busy); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (mdu_if.busy !== 1'b0 || mdu_if.done !== 1'b0) $display("FAIL areset_idle: got busy=%b done=%b expected 0/0", mdu_if.busy, mdu_if.done); else n_pass++;
    a = $urandom; b = $urandom;
    run_op(2'b11, a, b, 1'b0, 1'b0, 0, nb, nd, hi, lo);
    r = ref_mdu(2'b11, a, b);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    n_checks++; if (nb != 33 || nd != 1 || hi !== exp_hi || lo !== exp_lo) $display("FAIL areset_recover: got %h_%h busy=%0d done=%0d expected %h_%h 33/1", hi, lo, nb, nd, exp_hi, exp_lo); else n_pass++;
  endtask

  initial begin
    mdu_if.start = 1'b0; mdu_if.op = 2'b00; mdu_if.src_a = '0; mdu_if.src_b = '0;
    mdu_if.cancel = 1'b0; mdu_if.mthi = 1'b0; mdu_if.mtlo = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_moves();
    test_busy_ignores();
    test_cancel();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands (rs → src_a, rt → src_b) and executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Exposes busy so the hazard unit can stall dependent MFHI/MFLO and further mul/div instructions.

Parameters:
- WIDTH, 32: operand width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  WIDTH  rs operand; multiplicand/dividend
- src_b  input  WIDTH  rt operand; multiplier/divisor
- cancel  input  1  pipeline flush; aborts an in-flight operation
- mthi  input  1  write src_a into HI
- mtlo  input  1  write src_a into LO
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation

Behaviour:
- Reset (reset low, asynchronous, any state including mid-operation):
  - hi_out = 0, lo_out = 0, busy = 0, done = 0.
  - Internal accumulators and counter cleared; state = IDLE.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0: latch op and operand magnitudes (abs value for signed ops), record sign flags, counter = 0, go to RUN. busy = 1 from E0.
  - Else if mthi=1: HI ← src_a at the edge. Independently, if mtlo=1: LO ← src_a (both may be written in the same cycle).
- RUN: one iteration per edge, E1..E_WIDTH.
  - Multiply: shift-add over a 2×WIDTH product register.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After WIDTH iterations, go to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction and write HI/LO; busy = 0 and done = 1 for exactly the following cycle; return to IDLE.
  - Total: 33 busy cycles for WIDTH=32.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2×WIDTH product. Signed product is negated when operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient is negated when signs differ; signed remainder takes the dividend's sign.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (signed or unsigned): HI = src_a as latched, LO = all ones. Full latency is still taken; done still pulses.
- cancel:
  - When busy and not in reset, cancel=1 returns to IDLE at the next edge. HI/LO unchanged, no done pulse, busy low the next cycle.
  - cancel in IDLE has no effect; it does not block a simultaneous start.
- Ignored inputs:
  - start while busy is ignored.
  - mthi/mtlo while busy are ignored; the hazard unit stalls them.
  - start with mthi/mtlo in the same IDLE cycle: start wins, moves are dropped.
- Operands are captured only at E0; later changes to src_a/src_b have no effect.
- hi_out/lo_out are direct register outputs with no bypass; readers see new values the cycle after done rises.

Test Plan:
- MULT: src_a=0xFFFFFFFD, src_b=0x00000007, start 1 cycle → busy 33 cycles, single done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands → HI=0, LO=1.
- Division cases:
  - DIV −7/2 (0xFFFFFFF9, 0x2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 5/0 → HI=5, LO=0xFFFFFFFF.
- Moves:
  - mthi with src_a=0x00001234 in IDLE → HI=0x1234 next cycle, LO unchanged.
  - mtlo pulsed while busy → LO unchanged.
  - Second start while busy → ignored; first result intact.
- Abort:
  - cancel at 5th busy cycle of a DIV with HI=0xAAAA, LO=0x5555 preloaded → busy low next cycle, HI/LO unchanged, no done.
  - reset pulled low at 10th busy cycle → HI=LO=0, busy=0 immediately, without a clock edge.
